wb_commit_ctrl: RTL and testbench
=================================

# wb_commit_ctrl

Write-back commit controller for the Y86-64 core. It takes one retiring instruction per handshake, holding its `valE`/`valM` results and error flags. It serialises the results onto the register file's single write port, one or two writes per instruction. It also owns the architectural status register and halts the core on HLT, ADR or INS.

## Interface
- `DATA_W`, default 64, register/data width.
- `clk_i`  in  1  core clock, rising edge.
- `rst_i`  in  1  reset, asynchronous and active-high.
- `in_valid_i`  in  1  retiring instruction presented.
- `in_ready_o`  out  1  controller can accept; high only in IDLE.
- `icode_i`  in  4  instruction code.
- `dstE_i`, `dstM_i`  in  4  destination registers; 4'hF (RNONE) means no write.
- `valE_i`, `valM_i`  in  DATA_W  ALU result / memory read data.
- `instr_valid_i`, `imem_error_i`, `dmem_error_i`  in  1  instruction status flags.
- `rf_we_o`  out  1  register-file write enable.
- `rf_waddr_o`  out  4  write address.
- `rf_wdata_o`  out  DATA_W  write data.
- `stat_o`  out  3  status: AOK=1, HLT=2, ADR=3, INS=4.
- `halted_o`  out  1  core stopped.
- `commit_o`  out  1  one-cycle pulse when an instruction retires.

## Operation
- Accept when `in_valid_i && in_ready_o`. All inputs are latched on the accept edge, and only then.
- Status from the latched flags, priority order:
  - `imem_error` → ADR
  - `!instr_valid` → INS
  - `dmem_error` → ADR
  - `icode==0` (HALT) → HLT
  - otherwise AOK
- FSM states IDLE, WR_E, WR_M, DONE, HALT. Next state after an accept:
  - status ≠ AOK → HALT.
  - needE = (dstE≠F) && (dstE≠dstM). needM = dstM≠F.
  - needE → WR_E; else needM → WR_M; else → DONE.
- WR_E: `rf_we_o=1`, address dstE, data valE. Goes to WR_M if needM, else IDLE.
- WR_M: `rf_we_o=1`, address dstM, data valM. Goes to IDLE.
- When dstE==dstM≠F, only the valM write occurs; M has priority.
- DONE: no write. Goes to IDLE.
- `commit_o`=1 in the last cycle of the instruction (the final WR_x state or DONE). It is also 1 on entry to HALT when the status is HLT. It stays 0 for ADR/INS faults.
- HALT is terminal until reset:
  - `in_ready_o=0`, `halted_o=1`, `rf_we_o=0`.
  - `stat_o` holds the code. `in_valid_i` is ignored.
- A faulting instruction performs no register writes.
- While `rf_we_o=0`: `rf_waddr_o`=4'hF, `rf_wdata_o`=0.

## Timing
- Reset values, asserted asynchronously: state IDLE, `in_ready_o`=1, `rf_we_o`=0, `rf_waddr_o`=4'hF, `rf_wdata_o`=0, `stat_o`=AOK, `halted_o`=0, `commit_o`=0.
- Accept at edge T gives:
  - First write in cycle T+1.
  - Second write in T+2.
  - `in_ready_o` high again in the cycle after the last write/DONE.
  - Throughput: 2 cycles for 0 or 1 writes, 3 cycles for 2 writes.
- `stat_o` and `halted_o` update in cycle T+1 for a status change; they are registered.
- Write-port outputs are decoded from the state register and latched data only. There is no combinational path from the inputs.
- Reset asserted mid-WR_E/WR_M: `rf_we_o` drops immediately. The pending write is discarded.
- The controller does not accept a new instruction in the same cycle as a write or commit.

## Structure
- Shared package `y86_pkg` holds:
  - icode constants (IHALT=4'h0, …).
  - `RNONE`=4'hF.
  - Stat codes `STAT_AOK/HLT/ADR/INS`.
  - The FSM state enum.
- Sub-module `wb_stat_enc`: a combinational priority encoder from (icode, instr_valid, imem_error, dmem_error) to a 3-bit stat. The controller registers its output.

## Test plan
- Reset: after `rst_i` pulses, `in_ready_o`=1, `stat_o`=1, `rf_we_o`=0, `rf_waddr_o`=F, `halted_o`=0.
- OPq, one write: icode 6, dstE=3, dstM=F, valE=0x10 → at T+1 `rf_we_o`=1, addr 3, data 0x10, `commit_o`=1; at T+2 `in_ready_o`=1.
- popq, two writes: dstE=4, valE=0x100, dstM=0, valM=0xAB → T+1 write (4, 0x100); T+2 write (0, 0xAB) with `commit_o`=1.
- Same destination: dstE=dstM=4, valE=0x100, valM=0xAB → single write (4, 0xAB) at T+1; `commit_o`=1.
- dmem fault: mrmovq with `dmem_error_i`=1 → T+1 `stat_o`=3, `halted_o`=1, no write, `commit_o`=0. Later `in_valid_i` pulses are ignored. Reset restores AOK.
- Priority and HLT:
  - imem_error with !instr_valid → stat 3.
  - !instr_valid alone → stat 4.
  - icode 0 → stat 2 with `commit_o`=1.
  - Reset asserted during WR_E → `rf_we_o` drops in the same cycle.

Source files
------------

// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared Y86-64 definitions used by the write-back stage:
//   - instruction codes (icode field of the retiring instruction)
//   - RNONE register encoding (no destination)
//   - architectural status codes
//   - write-back commit FSM state encoding
//   - small helpers deciding which register-file writes an instruction needs
// -----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Architectural status codes
    typedef logic [2:0] stat_t;
    localparam stat_t STAT_AOK = 3'd1;
    localparam stat_t STAT_HLT = 3'd2;
    localparam stat_t STAT_ADR = 3'd3;
    localparam stat_t STAT_INS = 3'd4;

    // Write-back commit FSM states
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR_E = 3'd1,
        S_WR_M = 3'd2,
        S_DONE = 3'd3,
        S_HALT = 3'd4
    } wb_state_e;

    // valE is written only when it has a destination that the valM write
    // would not overwrite anyway (M wins when both target the same register).
    function automatic logic need_e_f(input logic [3:0] dst_e, input logic [3:0] dst_m);
        return (dst_e != RNONE) && (dst_e != dst_m);
    endfunction

    function automatic logic need_m_f(input logic [3:0] dst_m);
        return dst_m != RNONE;
    endfunction

endpackage

// File: rtl/wb_commit_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_commit_ctrl_if
// Bundle between the retire stage, the write-back commit controller and the
// register-file write port.
//   Retire handshake : in_valid_i / in_ready_o
//   Instruction data : icode_i, dstE_i, dstM_i, valE_i, valM_i
//   Status flags     : instr_valid_i, imem_error_i, dmem_error_i
//   Write port       : rf_we_o, rf_waddr_o, rf_wdata_o
//   Status           : stat_o, halted_o, commit_o
// Modports: master = producer of retiring instructions / consumer of results,
//           slave  = the commit controller.
// -----------------------------------------------------------------------------
interface wb_commit_ctrl_if #(
    parameter int DATA_W = 64
);
    logic              in_valid_i;
    logic              in_ready_o;
    logic [3:0]        icode_i;
    logic [3:0]        dstE_i;
    logic [3:0]        dstM_i;
    logic [DATA_W-1:0] valE_i;
    logic [DATA_W-1:0] valM_i;
    logic              instr_valid_i;
    logic              imem_error_i;
    logic              dmem_error_i;
    logic              rf_we_o;
    logic [3:0]        rf_waddr_o;
    logic [DATA_W-1:0] rf_wdata_o;
    logic [2:0]        stat_o;
    logic              halted_o;
    logic              commit_o;

    modport master (
        output in_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
               instr_valid_i, imem_error_i, dmem_error_i,
        input  in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               stat_o, halted_o, commit_o
    );

    modport slave (
        input  in_valid_i, icode_i, dstE_i, dstM_i, valE_i, valM_i,
               instr_valid_i, imem_error_i, dmem_error_i,
        output in_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o,
               stat_o, halted_o, commit_o
    );

endinterface

// File: rtl/wb_stat_enc.sv
// -----------------------------------------------------------------------------
// wb_stat_enc
// Combinational priority encoder producing the architectural status of a
// retiring instruction.
//   icode_i        in  4  instruction code
//   instr_valid_i  in  1  instruction decoded as valid
//   imem_error_i   in  1  instruction fetch address fault
//   dmem_error_i   in  1  data memory address fault
//   stat_o         out 3  AOK / HLT / ADR / INS
// A fetch fault outranks an invalid instruction, since the bytes that were
// judged invalid never came from a legal address in the first place.
// -----------------------------------------------------------------------------
module wb_stat_enc
    import y86_pkg::*;
(
    input  logic [3:0] icode_i,
    input  logic       instr_valid_i,
    input  logic       imem_error_i,
    input  logic       dmem_error_i,
    output stat_t      stat_o
);

    always_comb begin
        stat_o = STAT_AOK;
        if (imem_error_i)
            stat_o = STAT_ADR;
        else if (!instr_valid_i)
            stat_o = STAT_INS;
        else if (dmem_error_i)
            stat_o = STAT_ADR;
        else if (icode_i == IHALT)
            stat_o = STAT_HLT;
    end

endmodule

// File: rtl/wb_commit_ctrl.sv
// -----------------------------------------------------------------------------
// wb_commit_ctrl
// Write-back commit controller for the Y86-64 core. Accepts one retiring
// instruction per handshake, serialises its valE/valM results onto the single
// register-file write port and maintains the architectural status register.
//   clk_i  in  1  core clock, rising edge
//   rst_i  in  1  asynchronous active-high reset
//   bus    slave modport of wb_commit_ctrl_if (handshake, instruction data,
//          status flags, register-file write port, stat/halted/commit)
// All outputs are registered; the write port is driven only from the state
// register and values captured at the accept edge.
// -----------------------------------------------------------------------------
module wb_commit_ctrl
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
)(
    input  logic            clk_i,
    input  logic            rst_i,
    wb_commit_ctrl_if.slave bus
);

    wb_state_e         state;
    stat_t             stat_new;
    logic              accept;
    logic              need_e;
    logic              need_m;

    // Captured second-write operands and whether that write is pending
    logic              need_m_p0;
    logic [3:0]        dstm_p0;
    logic [DATA_W-1:0] valm_p0;

    wb_stat_enc u_stat_enc (
        .icode_i       (bus.icode_i),
        .instr_valid_i (bus.instr_valid_i),
        .imem_error_i  (bus.imem_error_i),
        .dmem_error_i  (bus.dmem_error_i),
        .stat_o        (stat_new)
    );

    assign accept = bus.in_valid_i && bus.in_ready_o;
    assign need_e = need_e_f(bus.dstE_i, bus.dstM_i);
    assign need_m = need_m_f(bus.dstM_i);

    // Accept edge: capture the valM write for use one cycle later
    always_ff @(posedge clk_i) begin
        if (accept) begin
            dstm_p0 <= bus.dstM_i;
            valm_p0 <= bus.valM_i;
        end
    end

    // Commit FSM with registered outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= S_IDLE;
            need_m_p0      <= 1'b0;
            bus.in_ready_o <= 1'b1;
            bus.rf_we_o    <= 1'b0;
            bus.rf_waddr_o <= RNONE;
            bus.rf_wdata_o <= '0;
            bus.stat_o     <= STAT_AOK;
            bus.halted_o   <= 1'b0;
            bus.commit_o   <= 1'b0;
        end else begin
            // Idle write port and no commit unless a branch below says otherwise
            bus.rf_we_o    <= 1'b0;
            bus.rf_waddr_o <= RNONE;
            bus.rf_wdata_o <= '0;
            bus.commit_o   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.stat_o     <= stat_new;
                        bus.in_ready_o <= 1'b0;
                        need_m_p0      <= need_m;
                        if (stat_new != STAT_AOK) begin
                            // Faulting or halting instruction: no writes at all
                            state        <= S_HALT;
                            bus.halted_o <= 1'b1;
                            bus.commit_o <= (stat_new == STAT_HLT);
                        end else if (need_e) begin
                            state          <= S_WR_E;
                            bus.rf_we_o    <= 1'b1;
                            bus.rf_waddr_o <= bus.dstE_i;
                            bus.rf_wdata_o <= bus.valE_i;
                            bus.commit_o   <= !need_m;
                        end else if (need_m) begin
                            state          <= S_WR_M;
                            bus.rf_we_o    <= 1'b1;
                            bus.rf_waddr_o <= bus.dstM_i;
                            bus.rf_wdata_o <= bus.valM_i;
                            bus.commit_o   <= 1'b1;
                        end else begin
                            state        <= S_DONE;
                            bus.commit_o <= 1'b1;
                        end
                    end
                end

                S_WR_E: begin
                    if (need_m_p0) begin
                        state          <= S_WR_M;
                        bus.rf_we_o    <= 1'b1;
                        bus.rf_waddr_o <= dstm_p0;
                        bus.rf_wdata_o <= valm_p0;
                        bus.commit_o   <= 1'b1;
                    end else begin
                        state          <= S_IDLE;
                        bus.in_ready_o <= 1'b1;
                    end
                end

                S_WR_M, S_DONE: begin
                    state          <= S_IDLE;
                    bus.in_ready_o <= 1'b1;
                end

                S_HALT: begin
                    // Terminal until reset; inputs are ignored
                    state          <= S_HALT;
                    bus.in_ready_o <= 1'b0;
                    bus.halted_o   <= 1'b1;
                end

                default: begin
                    state          <= S_IDLE;
                    bus.in_ready_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_commit_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_commit_ctrl
// Self-checking bench for wb_commit_ctrl: a table of non-faulting retiring
// instructions with their expected per-cycle write-port behaviour, applied
// through a scoreboard queue, plus hand-written fault/halt/reset sequences.
// -----------------------------------------------------------------------------
module tb_wb_commit_ctrl;

    logic clk;
    logic rst;

    wb_commit_ctrl_if #(.DATA_W(64)) bus ();

    wb_commit_ctrl #(.DATA_W(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  a;
        logic [63:0] d;
        logic        c;
    } cyc_t;

    typedef struct {
        string       nm;
        logic [3:0]  icode;
        logic [3:0]  dste;
        logic [3:0]  dstm;
        logic [63:0] vale;
        logic [63:0] valm;
        int          ncyc;
        cyc_t        e0;
        cyc_t        e1;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    cyc_t exp_q[$];
    vec_t vecs[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] icode, input logic [3:0] dste,
                         input logic [3:0] dstm, input logic [63:0] vale, input logic [63:0] valm,
                         input logic iv, input logic ie, input logic de);
        bus.in_valid_i    = v;
        bus.icode_i       = icode;
        bus.dstE_i        = dste;
        bus.dstM_i        = dstm;
        bus.valE_i        = vale;
        bus.valM_i        = valm;
        bus.instr_valid_i = iv;
        bus.imem_error_i  = ie;
        bus.dmem_error_i  = de;
    endtask

    // Leaves the bench at a negedge with reset released and the DUT idle
    task automatic do_reset();
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again
    task automatic run_vec(input vec_t v);
        cyc_t e;
        int   guard;
        chk({v.nm, " ready_before"}, {63'd0, bus.in_ready_o}, 64'd1);
        drive(1'b1, v.icode, v.dste, v.dstm, v.vale, v.valm, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(v.e0);
        if (v.ncyc == 2) exp_q.push_back(v.e1);
        guard = 0;
        while (exp_q.size() > 0 && guard < 8) begin
            @(negedge clk);
            bus.in_valid_i = 1'b0;
            e = exp_q.pop_front();
            chk({v.nm, " we"},     {63'd0, bus.rf_we_o},    {63'd0, e.we});
            chk({v.nm, " waddr"},  {60'd0, bus.rf_waddr_o}, {60'd0, e.a});
            chk({v.nm, " wdata"},  bus.rf_wdata_o,          e.d);
            chk({v.nm, " commit"}, {63'd0, bus.commit_o},   {63'd0, e.c});
            chk({v.nm, " busy"},   {63'd0, bus.in_ready_o}, 64'd0);
            guard++;
        end
        @(negedge clk);
        chk({v.nm, " ready_after"}, {63'd0, bus.in_ready_o}, 64'd1);
        chk({v.nm, " idle_we"},     {63'd0, bus.rf_we_o},    64'd0);
        chk({v.nm, " idle_commit"}, {63'd0, bus.commit_o},   64'd0);
        chk({v.nm, " stat_aok"},    {61'd0, bus.stat_o},     64'd1);
    endtask

    task automatic run_fault(input string nm, input logic [3:0] icode, input logic iv,
                             input logic ie, input logic de, input logic [2:0] es, input logic ec);
        do_reset();
        drive(1'b1, icode, 4'h3, 4'h5, 64'h77, 64'h88, iv, ie, de);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        chk({nm, " stat"},   {61'd0, bus.stat_o},     {61'd0, es});
        chk({nm, " halted"}, {63'd0, bus.halted_o},   64'd1);
        chk({nm, " we"},     {63'd0, bus.rf_we_o},    64'd0);
        chk({nm, " waddr"},  {60'd0, bus.rf_waddr_o}, 64'hF);
        chk({nm, " commit"}, {63'd0, bus.commit_o},   {63'd0, ec});
        chk({nm, " ready"},  {63'd0, bus.in_ready_o}, 64'd0);
        @(negedge clk);
        chk({nm, " commit_pulse"}, {63'd0, bus.commit_o}, 64'd0);
        chk({nm, " stat_hold"},    {61'd0, bus.stat_o},   {61'd0, es});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(1'b0, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);

        //            name        icode  dstE   dstM   valE                    valM       ncyc  first cycle                          second cycle
        vecs[0] = '{"opq",      4'h6, 4'h3, 4'hF, 64'h10,                 64'h99,    1, '{1'b1, 4'h3, 64'h10, 1'b1},      '{1'b0, 4'hF, 64'h0, 1'b0}};
        vecs[1] = '{"popq",     4'hB, 4'h4, 4'h0, 64'h100,                64'hAB,    2, '{1'b1, 4'h4, 64'h100, 1'b0},     '{1'b1, 4'h0, 64'hAB, 1'b1}};
        vecs[2] = '{"samedst",  4'hB, 4'h4, 4'h4, 64'h100,                64'hAB,    1, '{1'b1, 4'h4, 64'hAB, 1'b1},      '{1'b0, 4'hF, 64'h0, 1'b0}};
        vecs[3] = '{"nop",      4'h1, 4'hF, 4'hF, 64'h1234,               64'h5678,  1, '{1'b0, 4'hF, 64'h0, 1'b1},       '{1'b0, 4'hF, 64'h0, 1'b0}};
        vecs[4] = '{"mrmovq",   4'h5, 4'hF, 4'h7, 64'h40,                 64'h55,    1, '{1'b1, 4'h7, 64'h55, 1'b1},      '{1'b0, 4'hF, 64'h0, 1'b0}};
        vecs[5] = '{"irmovq",   4'h3, 4'hE, 4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,    1, '{1'b1, 4'hE, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1}, '{1'b0, 4'hF, 64'h0, 1'b0}};
        vecs[6] = '{"popq_rsp", 4'hB, 4'hC, 4'hA, 64'hDEAD_BEEF_0000_0001, 64'hCAFE, 2, '{1'b1, 4'hC, 64'hDEAD_BEEF_0000_0001, 1'b0}, '{1'b1, 4'hA, 64'hCAFE, 1'b1}};

        // Asynchronous reset: outputs must take reset values before any edge
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_ready", {63'd0, bus.in_ready_o}, 64'd1);
        chk("rst_async_we",    {63'd0, bus.rf_we_o},    64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {63'd0, bus.in_ready_o}, 64'd1);
        chk("rst_stat",   {61'd0, bus.stat_o},     64'd1);
        chk("rst_we",     {63'd0, bus.rf_we_o},    64'd0);
        chk("rst_waddr",  {60'd0, bus.rf_waddr_o}, 64'hF);
        chk("rst_wdata",  bus.rf_wdata_o,          64'd0);
        chk("rst_halted", {63'd0, bus.halted_o},   64'd0);
        chk("rst_commit", {63'd0, bus.commit_o},   64'd0);

        // Back-to-back table vectors
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Data memory fault, then ignored requests, then recovery by reset
        run_fault("dmem", 4'h5, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 4'h6, 4'h2, 4'hF, 64'h5, 64'h0, 1'b1, 1'b0, 1'b0);
            @(negedge clk);
            chk("dmem_ignored_we",   {63'd0, bus.rf_we_o},    64'd0);
            chk("dmem_ignored_stat", {61'd0, bus.stat_o},     64'd3);
            chk("dmem_ignored_rdy",  {63'd0, bus.in_ready_o}, 64'd0);
        end
        bus.in_valid_i = 1'b0;
        do_reset();
        chk("dmem_recover_stat",   {61'd0, bus.stat_o},     64'd1);
        chk("dmem_recover_halted", {63'd0, bus.halted_o},   64'd0);
        chk("dmem_recover_ready",  {63'd0, bus.in_ready_o}, 64'd1);

        // Status priority and HLT
        run_fault("imem_ins", 4'h6, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0);
        run_fault("ins",      4'h6, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0);
        run_fault("ins_dmem", 4'h5, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
        run_fault("halt",     4'h0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1);

        // Reset during WR_E discards the pending write immediately
        do_reset();
        drive(1'b1, 4'hB, 4'h4, 4'h0, 64'h100, 64'hAB, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        chk("rstwr_we_before", {63'd0, bus.rf_we_o}, 64'd1);
        rst = 1'b1;
        #1;
        chk("rstwr_we_drop",    {63'd0, bus.rf_we_o},    64'd0);
        chk("rstwr_waddr_drop", {60'd0, bus.rf_waddr_o}, 64'hF);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstwr_no_second", {63'd0, bus.rf_we_o},    64'd0);
        chk("rstwr_ready",     {63'd0, bus.in_ready_o}, 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
